// File: rtl/tone_sequencer.sv
// tone_sequencer -- step-table driven tone player for a codec DAC path.
//
// Plays up to eight programmed steps in order. Each step selects a waveform
// and a PLL frequency and lasts a programmed number of codec sample pulses.
// The sequence either ends (one-cycle done pulse) or loops back to step 0.
//
// Build option:
//   TONE_SEQ_GAP_EN  when defined, every step (including the last) is followed
//                    by GAP_LEN muted sample pulses before the advance decision.
//                    When undefined, steps run back to back and the output is
//                    muted only during the single-cycle LOAD.
//
// Parameters:
//   GAP_LEN     muted sample_req pulses between steps (1..65535)
//
// Ports:
//   clk         audio clock, rising edge
//   reset_n     asynchronous active-low reset (also clears the step table)
//   sample_req  one-cycle pulse per codec sample
//   start       level-sampled start request (honoured only in IDLE)
//   stop        level-sampled abort request (wins over everything else)
//   loop_en     restart from step 0 at sequence end instead of idling
//   num_steps   index of the last step to play
//   wr_en       step-table write strobe
//   wr_addr     step-table write address
//   wr_data     {wave_sel[20:18], freq_sel[17:16], duration[15:0]}
//   wave_sel    waveform-mux select
//   freq_sel    PLL frequency select
//   mute        1 = silence the DAC path (low only while playing)
//   busy        1 outside IDLE
//   step_idx    current step
//   done        one-cycle pulse on non-looping completion
module tone_sequencer #(
   parameter int unsigned GAP_LEN = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sample_req,
   input  logic        start,
   input  logic        stop,
   input  logic        loop_en,
   input  logic [2:0]  num_steps,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [20:0] wr_data,
   output logic [2:0]  wave_sel,
   output logic [1:0]  freq_sel,
   output logic        mute,
   output logic        busy,
   output logic [2:0]  step_idx,
   output logic        done
);

   // Elaboration-time range check on the gap length.
   if (GAP_LEN < 1 || GAP_LEN > 65535) begin : g_bad_gap_len
      $error("tone_sequencer: GAP_LEN must be in 1..65535");
   end

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_PLAY = 2'd2;
`ifdef TONE_SEQ_GAP_EN
   localparam logic [1:0] ST_GAP  = 2'd3;
   localparam logic [15:0] GAP_LOAD = GAP_LEN[15:0];
`endif

   logic [1:0]  state_q,    state_d;
   logic [2:0]  step_idx_q, step_idx_d;
   logic [2:0]  wave_q,     wave_d;
   logic [1:0]  freq_q,     freq_d;
   logic [15:0] dur_cnt_q,  dur_cnt_d;
   logic        done_q,     done_d;
   logic [20:0] table_q [0:7];
   logic [20:0] table_d [0:7];
`ifdef TONE_SEQ_GAP_EN
   logic [15:0] gap_cnt_q,  gap_cnt_d;
`endif

   logic [20:0] entry;
   logic        step_end;

   // Table writes land on the same edge in any state; LOAD reads the
   // registered copy, so a write to the active step only shows up at its
   // next LOAD.
   always_comb begin
      table_d = table_q;
      if (wr_en) begin
         table_d[wr_addr] = wr_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      step_idx_d = step_idx_q;
      wave_d     = wave_q;
      freq_d     = freq_q;
      dur_cnt_d  = dur_cnt_q;
      done_d     = 1'b0;
`ifdef TONE_SEQ_GAP_EN
      gap_cnt_d  = gap_cnt_q;
`endif
      entry      = table_q[step_idx_q];
      step_end   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d    = ST_LOAD;
               step_idx_d = 3'd0;
            end
         end
         ST_LOAD: begin
            wave_d    = entry[20:18];
            freq_d    = entry[17:16];
            // A zero duration still plays for one sample.
            dur_cnt_d = (entry[15:0] == 16'd0) ? 16'd1 : entry[15:0];
            state_d   = ST_PLAY;
         end
         ST_PLAY: begin
            if (sample_req) begin
               if (dur_cnt_q == 16'd1) begin
                  dur_cnt_d = 16'd0;
`ifdef TONE_SEQ_GAP_EN
                  state_d   = ST_GAP;
                  gap_cnt_d = GAP_LOAD;
`else
                  step_end  = 1'b1;
`endif
               end else begin
                  dur_cnt_d = dur_cnt_q - 16'd1;
               end
            end
         end
`ifdef TONE_SEQ_GAP_EN
         ST_GAP: begin
            if (sample_req) begin
               if (gap_cnt_q == 16'd1) begin
                  gap_cnt_d = 16'd0;
                  step_end  = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q - 16'd1;
               end
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Advance decision: num_steps and loop_en are only looked at here.
      if (step_end) begin
         if (step_idx_q < num_steps) begin
            step_idx_d = step_idx_q + 3'd1;
            state_d    = ST_LOAD;
         end else if (loop_en) begin
            step_idx_d = 3'd0;
            state_d    = ST_LOAD;
         end else begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
         end
      end

      // Abort overrides a simultaneous step completion and suppresses done.
      if (stop && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         step_idx_d = 3'd0;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         step_idx_q <= 3'd0;
         wave_q     <= 3'd0;
         freq_q     <= 2'd0;
         dur_cnt_q  <= 16'd0;
         done_q     <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
         gap_cnt_q  <= 16'd0;
`endif
         for (int i = 0; i < 8; i++) begin
            table_q[i] <= 21'd0;
         end
      end else begin
         state_q    <= state_d;
         step_idx_q <= step_idx_d;
         wave_q     <= wave_d;
         freq_q     <= freq_d;
         dur_cnt_q  <= dur_cnt_d;
         done_q     <= done_d;
`ifdef TONE_SEQ_GAP_EN
         gap_cnt_q  <= gap_cnt_d;
`endif
         for (int i = 0; i < 8; i++) begin
            table_q[i] <= table_d[i];
         end
      end
   end

   assign wave_sel = wave_q;
   assign freq_sel = freq_q;
   assign mute     = (state_q != ST_PLAY);
   assign busy     = (state_q != ST_IDLE);
   assign step_idx = step_idx_q;
   assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Testbench for tone_sequencer. A per-sample-pulse reference model tracks
// which step is sounding, how many pulses it has left and the gap phase;
// outputs are compared just before each sample pulse is issued and the done
// pulse right after it.
module tb_tone_sequencer;

   localparam int GAP_LEN = 4;
`ifdef TONE_SEQ_GAP_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sample_req;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic [2:0]  num_steps;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [20:0] wr_data;
   logic [2:0]  wave_sel;
   logic [1:0]  freq_sel;
   logic        mute;
   logic        busy;
   logic [2:0]  step_idx;
   logic        done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tone_sequencer #(.GAP_LEN(GAP_LEN)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sample_req (sample_req),
      .start      (start),
      .stop       (stop),
      .loop_en    (loop_en),
      .num_steps  (num_steps),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wave_sel   (wave_sel),
      .freq_sel   (freq_sel),
      .mute       (mute),
      .busy       (busy),
      .step_idx   (step_idx),
      .done       (done)
   );

   // ---------------- reference model ----------------
   logic [20:0] m_tbl [8];
   logic [2:0]  m_step;
   int          m_left;      // play pulses left in current step
   int          m_gap_left;  // gap pulses left (only when m_left == 0)
   logic [2:0]  m_wave;
   logic [1:0]  m_freq;
   bit          m_active;
   bit          m_exp_done;
   int          done_exp  = 0;
   int          done_seen = 0;

   always @(negedge clk) begin
      if (done === 1'b1) done_seen++;
   end

   function automatic void m_load();
      logic [20:0] e;
      e          = m_tbl[m_step];
      m_wave     = e[20:18];
      m_freq     = e[17:16];
      m_left     = (e[15:0] == 16'd0) ? 1 : int'(e[15:0]);
      m_gap_left = 0;
   endfunction

   function automatic void m_advance();
      if (m_step < num_steps) begin
         m_step = m_step + 3'd1;
         m_load();
      end else if (loop_en) begin
         m_step = 3'd0;
         m_load();
      end else begin
         m_active   = 1'b0;
         m_exp_done = 1'b1;
         done_exp++;
      end
   endfunction

   function automatic void m_consume();
      m_exp_done = 1'b0;
      if (!m_active) return;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            if (GAP_ON) m_gap_left = GAP_LEN;
            else        m_advance();
         end
      end else begin
         m_gap_left--;
         if (m_gap_left == 0) m_advance();
      end
   endfunction

   function automatic int m_total_pulses(input int ns);
      int t;
      t = 0;
      for (int s = 0; s <= ns; s++) begin
         t += (m_tbl[s][15:0] == 16'd0) ? 1 : int'(m_tbl[s][15:0]);
         if (GAP_ON) t += GAP_LEN;
      end
      return t;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic write_entry(input logic [2:0] a, input logic [20:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      m_tbl[a] = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic do_start();
      start      = 1'b1;
      sample_req = 1'($urandom_range(0, 1));   // IDLE ignores it
      m_active   = 1'b1;
      m_step     = 3'd0;
      m_load();
      @(negedge clk);
      start      = 1'b0;
      sample_req = 1'($urandom_range(0, 1));   // lands in LOAD, ignored
      @(negedge clk);
      sample_req = 1'b0;
   endtask

   // One sample pulse: compare outputs, pulse, compare done, then idle
   // cycles with optional random side activity (table writes, control edits).
   task automatic play_pulse(input string tag, input bit side);
      int k;
      if (m_active) begin
         checks++;
         if (wave_sel !== m_wave || freq_sel !== m_freq || step_idx !== m_step ||
             mute !== (m_left == 0) || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s active: wave=%b freq=%b step=%0d mute=%b busy=%b required wave=%b freq=%b step=%0d mute=%b busy=1",
                     tag, wave_sel, freq_sel, step_idx, mute, busy, m_wave, m_freq, m_step, (m_left == 0));
         end
      end else begin
         checks++;
         if (busy !== 1'b0 || mute !== 1'b1 || wave_sel !== m_wave || freq_sel !== m_freq) begin
            errors++;
            $display("FAIL %s idle: busy=%b mute=%b wave=%b freq=%b required busy=0 mute=1 wave=%b freq=%b",
                     tag, busy, mute, wave_sel, freq_sel, m_wave, m_freq);
         end
      end
      sample_req = 1'b1;
      m_consume();
      @(negedge clk);
      sample_req = 1'b0;
      checks++;
      if (done !== m_exp_done) begin
         errors++;
         $display("FAIL %s done: got %b required %b", tag, done, m_exp_done);
      end
      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) begin
         if (side) begin
            case ($urandom_range(0, 5))
               0: begin
                  wr_en   = 1'b1;
                  wr_addr = 3'($urandom_range(0, 7));
                  wr_data = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
                  m_tbl[wr_addr] = wr_data;
               end
               1: num_steps = 3'($urandom_range(0, 7));
               2: loop_en   = ~loop_en;
               default: ;
            endcase
         end
         @(negedge clk);
         wr_en = 1'b0;
      end
   endtask

   task automatic do_stop(input string tag, input bit with_pulse);
      stop = 1'b1;
      if (with_pulse) sample_req = 1'b1;
      @(negedge clk);
      stop       = 1'b0;
      sample_req = 1'b0;
      m_active   = 1'b0;
      m_step     = 3'd0;
      checks++;
      if (busy !== 1'b0 || mute !== 1'b1 || step_idx !== 3'd0 || done !== 1'b0 || wave_sel !== m_wave) begin
         errors++;
         $display("FAIL %s stop: busy=%b mute=%b step=%0d done=%b wave=%b required 0 1 0 0 wave=%b",
                  tag, busy, mute, step_idx, done, wave_sel, m_wave);
      end
   endtask

   task automatic run_to_end(input string tag, input bit side);
      int n;
      n = 0;
      while (m_active && n < 200) begin
         play_pulse(tag, side);
         n++;
      end
      checks++;
      if (m_active) begin
         errors++;
         $display("FAIL %s bound: sequence still active after %0d pulses, required end", tag, n);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (wave_sel !== 3'd0) begin errors++; $display("FAIL reset wave_sel: got %b required 000", wave_sel); end
      checks++; if (freq_sel !== 2'd0) begin errors++; $display("FAIL reset freq_sel: got %b required 00", freq_sel); end
      checks++; if (mute !== 1'b1) begin errors++; $display("FAIL reset mute: got %b required 1", mute); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
      checks++; if (step_idx !== 3'd0) begin errors++; $display("FAIL reset step_idx: got %0d required 0", step_idx); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b required 0", done); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_two_step();
      write_entry(3'd0, {3'b001, 2'b01, 16'd3});
      write_entry(3'd1, {3'b011, 2'b10, 16'd2});
      num_steps = 3'd1;
      loop_en   = 1'b0;
      do_start();
      run_to_end("two_step", 1'b0);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL two_step busy_end: got %b required 0", busy); end
   endtask

   task automatic test_loop();
      int d0;
      d0 = done_seen;
      num_steps = 3'd1;
      loop_en   = 1'b1;
      do_start();
      for (int i = 0; i < 20; i++) play_pulse("loop", 1'b0);
      checks++;
      if (done_seen != d0) begin errors++; $display("FAIL loop done_count: got %0d required 0", done_seen - d0); end
      do_stop("loop", 1'b0);
      loop_en = 1'b0;
   endtask

   task automatic test_gap();
      write_entry(3'd0, {3'b110, 2'b11, 16'd2});
      num_steps = 3'd0;
      loop_en   = 1'b0;
      do_start();
      run_to_end("gap", 1'b0);
   endtask

   task automatic test_dur_zero();
      int n;
      write_entry(3'd0, {3'b010, 2'b00, 16'd0});
      num_steps = 3'd0;
      loop_en   = 1'b0;
      do_start();
      n = 0;
      while (m_active && n < 50) begin
         play_pulse("dur_zero", 1'b0);
         n++;
      end
      checks++;
      if (n != 1 + (GAP_ON ? GAP_LEN : 0)) begin
         errors++;
         $display("FAIL dur_zero pulses: got %0d required %0d", n, 1 + (GAP_ON ? GAP_LEN : 0));
      end
   endtask

   task automatic test_stop_final();
      int total;
      int d0;
      write_entry(3'd0, {3'b001, 2'b01, 16'd3});
      write_entry(3'd1, {3'b011, 2'b10, 16'd2});
      num_steps = 3'd1;
      loop_en   = 1'b0;
      total = m_total_pulses(1);
      do_start();
      for (int i = 0; i < total - 1; i++) play_pulse("stop_final", 1'b0);
      d0 = done_seen;
      do_stop("stop_final", 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (done_seen != d0) begin errors++; $display("FAIL stop_final done_count: got %0d required 0", done_seen - d0); end
      // start and stop together in IDLE
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mute !== 1'b1) begin
         errors++;
         $display("FAIL start_with_stop: busy=%b mute=%b required busy=0 mute=1", busy, mute);
      end
   endtask

   task automatic test_write_active();
      write_entry(3'd0, {3'b001, 2'b01, 16'd3});
      num_steps = 3'd0;
      loop_en   = 1'b1;
      do_start();
      play_pulse("write_active", 1'b0);
      write_entry(3'd0, {3'b011, 2'b10, 16'd2});
      for (int i = 0; i < 10; i++) play_pulse("write_active", 1'b0);
      do_stop("write_active", 1'b0);
      loop_en = 1'b0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         for (int a = 0; a < 8; a++) begin
            write_entry(3'(a), {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 16'($urandom_range(0, 3))});
         end
         num_steps = 3'($urandom_range(0, 7));
         loop_en   = 1'($urandom_range(0, 1));
         do_start();
         for (int p = 0; p < 40 && m_active; p++) play_pulse("random", 1'b1);
         if (m_active) do_stop("random", 1'b0);
         loop_en = 1'b0;
      end
   endtask

   task automatic test_async_reset();
      int d0;
      write_entry(3'd0, {3'b011, 2'b10, 16'd5});
      num_steps = 3'd0;
      loop_en   = 1'b0;
      do_start();
      play_pulse("async_reset", 1'b0);
      play_pulse("async_reset", 1'b0);
      d0 = done_seen;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (wave_sel !== 3'd0 || freq_sel !== 2'd0 || mute !== 1'b1 || busy !== 1'b0 ||
          step_idx !== 3'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset outputs: wave=%b freq=%b mute=%b busy=%b step=%0d done=%b required 000 00 1 0 0 0",
                  wave_sel, freq_sel, mute, busy, step_idx, done);
      end
      for (int a = 0; a < 8; a++) m_tbl[a] = 21'd0;
      m_active = 1'b0;
      m_wave   = 3'd0;
      m_freq   = 2'd0;
      m_step   = 3'd0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (done_seen != d0) begin errors++; $display("FAIL async_reset done_count: got %0d required 0", done_seen - d0); end
      // Cleared table: step 0 now has duration 0 (one pulse) and wave 000.
      do_start();
      run_to_end("after_reset", 1'b0);
   endtask

   initial begin
      reset_n    = 1'b0;
      sample_req = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      loop_en    = 1'b0;
      num_steps  = 3'd0;
      wr_en      = 1'b0;
      wr_addr    = 3'd0;
      wr_data    = 21'd0;
      for (int a = 0; a < 8; a++) m_tbl[a] = 21'd0;
      m_step = 3'd0; m_left = 0; m_gap_left = 0;
      m_wave = 3'd0; m_freq = 2'd0; m_active = 1'b0; m_exp_done = 1'b0;

      test_reset();
      test_two_step();
      test_loop();
      test_gap();
      test_dur_zero();
      test_stop_final();
      test_write_active();
      test_random();
      test_async_reset();

      repeat (2) @(negedge clk);
      checks++;
      if (done_seen != done_exp) begin
         errors++;
         $display("FAIL done_total: got %0d required %0d", done_seen, done_exp);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 The block SHALL have one parameter: GAP_LEN, default 64, number of sample_req pulses muted between steps (1..65535).
REQ-002 The block SHALL have port clk  input  1  audio clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port sample_req  input  1  one-cycle pulse per codec sample.
REQ-005 The block SHALL have port start  input  1  level-sampled playback start request.
REQ-006 The block SHALL have port stop  input  1  level-sampled abort request.
REQ-007 The block SHALL have port loop_en  input  1  at sequence end, restart from step 0 instead of idling.
REQ-008 The block SHALL have port num_steps  input  3  index of last step (0..7, i.e. 1..8 steps).
REQ-009 The block SHALL have port wr_en  input  1  step-table write strobe.
REQ-010 The block SHALL have port wr_addr  input  3  step-table write address.
REQ-011 The block SHALL have port wr_data  input  21  {wave_sel[20:18], freq_sel[17:16], duration[15:0]}.
REQ-012 The block SHALL have port wave_sel  output  3  waveform-mux select (000 sine, 001 square, 011 triangle, 110 sawtooth, 010 ecg).
REQ-013 The block SHALL have port freq_sel  output  2  PLL frequency select.
REQ-014 The block SHALL have port mute  output  1  1 = silence the DAC path.
REQ-015 The block SHALL have ports busy  output  1  and step_idx  output  3: busy is 1 outside IDLE; step_idx is the current step.
REQ-016 The block SHALL have port done  output  1  one-cycle pulse on non-looping sequence completion.

Function
REQ-017 The block SHALL hold an 8-entry x 21-bit register step table; wr_en writes wr_data to wr_addr on the same edge, in any state; a write to the active step takes effect only at that step's next LOAD.
REQ-018 The block SHALL implement states IDLE, LOAD, PLAY, GAP.
REQ-019 The block SHALL transition IDLE->LOAD on start=1 and stop=0, setting step_idx=0; start outside IDLE SHALL be ignored.
REQ-020 The block SHALL, in LOAD (exactly one cycle), register wave_sel/freq_sel from table[step_idx], load a 16-bit down-counter with duration (0 treated as 1), and enter PLAY.
REQ-021 The block SHALL decrement the counter on each sample_req in PLAY; the sample_req that brings it to 0 SHALL end PLAY on the next edge, so PLAY spans exactly duration pulses.
REQ-022 The block SHALL, at PLAY end, enter GAP when gaps are compiled in, otherwise advance directly (REQ-023).
REQ-023 The block SHALL advance as follows: if step_idx<num_steps then step_idx+1 and LOAD; else if loop_en then step_idx=0 and LOAD; else IDLE with done=1 for one cycle.
REQ-024 The block SHALL drive mute=0 only in PLAY and mute=1 in IDLE, LOAD and GAP.
REQ-025 The block SHALL, on stop=1 in any non-IDLE state, enter IDLE on the next edge with mute=1, step_idx=0, no done pulse; stop SHALL win over simultaneous start or step completion.
REQ-026 The block SHALL sample num_steps and loop_en only at the advance decision; changes mid-step SHALL not disturb the current step.
REQ-027 The block SHALL ignore sample_req in IDLE and LOAD.
REQ-028 The block SHALL keep wave_sel/freq_sel at their last values in GAP and IDLE.

Reset
REQ-029 The block SHALL, while reset_n=0, force state=IDLE, wave_sel=000, freq_sel=00, mute=1, busy=0, step_idx=0, done=0 and counters to 0 asynchronously; the step table SHALL also clear to 0.
REQ-030 The block SHALL leave IDLE only on a start seen at a rising edge after reset_n deasserts; reset mid-sequence SHALL abort with no done pulse.

Configuration
REQ-031 The block SHALL, with macro TONE_SEQ_GAP_EN defined, include GAP: GAP_LEN sample_req pulses with mute=1 after every step, including the last, before the advance decision.
REQ-032 The block SHALL, without TONE_SEQ_GAP_EN, omit GAP state logic and its counter; steps run back to back, muted only during the one-cycle LOAD.

Verification
REQ-033 Write steps 0:{001,01,3}, 1:{011,10,2}; num_steps=1, loop_en=0, start -> PLAY step0 exactly 3 sample_req, step1 exactly 2, wave_sel 001 then 011, one done pulse, busy falls.
REQ-034 Same table, loop_en=1, 20 sample_req, gaps off -> wave_sel cycles 001,011,001,... with step_idx wrapping 1->0, never done.
REQ-035 TONE_SEQ_GAP_EN, GAP_LEN=4, step0 duration 2 -> mute=0 for 2 pulses, then mute=1 for 4 pulses before done.
REQ-036 Duration 0 at step 0 -> step plays exactly 1 sample_req.
REQ-037 stop asserted in the same cycle as the final sample_req of the last step -> IDLE, no done, mute=1; start with stop both high in IDLE -> stays IDLE.
REQ-038 reset_n pulsed low mid-PLAY, asynchronous to clk -> all outputs at reset values immediately, table cleared, no done.
